// File: rtl/bip_report_unit.sv
// BIP report unit: gates the CPU, counts executed cycles and, when the HALT
// opcode appears on the program-memory bus, snapshots PC/ACC/cycle count and
// streams an 8-byte report frame to the UART transmitter one byte at a time.
module bip_report_unit #(
  parameter logic [4:0] HALT_OPCODE = 5'b00000,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] INSTRUCTION,
  input  logic [10:0] ADDR_PM,
  input  logic [15:0] ACC,
  input  logic        TX_DONE,
  output logic        CPU_EN,
  output logic [7:0]  TX_DATA,
  output logic        TX_START,
  output logic        FINISHED
);

  typedef enum logic [2:0] {StIdle, StRun, StSend, StWaitTx, StDone} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [10:0] pc_s_q;
  logic [15:0] acc_s_q;
  logic [15:0] cyc_s_q;

  logic        halt_hit;
  logic [15:0] cnt_inc;
  logic [2:0]  next_idx;
  logic [7:0]  next_byte;
  logic [7:0]  checksum;

  // Only the opcode field of the instruction is decoded here.
  logic unused_instr;
  assign unused_instr = ^INSTRUCTION[10:0];

  assign halt_hit = (INSTRUCTION[15:11] == HALT_OPCODE);
  // Saturating increment: a runaway program pins the count at 16'hFFFF.
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign next_idx = idx_q + 3'd1;

  // Frame byte for the slot that follows the one currently in flight.
  always_comb begin
    checksum = HEADER ^ {5'b00000, pc_s_q[10:8]} ^ pc_s_q[7:0] ^ acc_s_q[15:8] ^
               acc_s_q[7:0] ^ cyc_s_q[15:8] ^ cyc_s_q[7:0];
    case (next_idx)
      3'd0:    next_byte = HEADER;
      3'd1:    next_byte = {5'b00000, pc_s_q[10:8]};
      3'd2:    next_byte = pc_s_q[7:0];
      3'd3:    next_byte = acc_s_q[15:8];
      3'd4:    next_byte = acc_s_q[7:0];
      3'd5:    next_byte = cyc_s_q[15:8];
      3'd6:    next_byte = cyc_s_q[7:0];
      default: next_byte = checksum;
    endcase
  end

  // Control FSM with registered outputs; reset aborts any run or frame at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      cnt_q    <= 16'h0000;
      idx_q    <= 3'd0;
      pc_s_q   <= 11'h000;
      acc_s_q  <= 16'h0000;
      cyc_s_q  <= 16'h0000;
      CPU_EN   <= 1'b0;
      TX_DATA  <= 8'h00;
      TX_START <= 1'b0;
      FINISHED <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= 16'h0000;
          if (START) begin
            state_q <= StRun;
            CPU_EN  <= 1'b1;
          end
        end
        StRun: begin
          cnt_q <= cnt_inc;
          if (halt_hit) begin
            // The halt cycle itself is counted in the snapshot.
            CPU_EN   <= 1'b0;
            pc_s_q   <= ADDR_PM;
            acc_s_q  <= ACC;
            cyc_s_q  <= cnt_inc;
            idx_q    <= 3'd0;
            TX_DATA  <= HEADER;
            TX_START <= 1'b1;
            state_q  <= StSend;
          end
        end
        StSend: begin
          TX_START <= 1'b0;
          state_q  <= StWaitTx;
        end
        StWaitTx: begin
          if (TX_DONE) begin
            if (idx_q == 3'd7) begin
              FINISHED <= 1'b1;
              state_q  <= StDone;
            end else begin
              idx_q    <= next_idx;
              TX_DATA  <= next_byte;
              TX_START <= 1'b1;
              state_q  <= StSend;
            end
          end
        end
        StDone: begin
          FINISHED <= 1'b1;
          CPU_EN   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_report_unit.sv
// Self-checking bench for bip_report_unit: the bench plays both the CPU and the
// UART, and checks the report frame against a model built from PC/ACC/cycles.
module tb_bip_report_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [15:0] INSTRUCTION = 16'h0000;
  logic [10:0] ADDR_PM = 11'h000;
  logic [15:0] ACC = 16'h0000;
  logic        TX_DONE = 1'b0;
  logic        CPU_EN;
  logic [7:0]  TX_DATA;
  logic        TX_START;
  logic        FINISHED;

  int errors = 0;
  int checks = 0;

  // Observations gathered by run_program.
  int         en_cycles;
  int         run_tx_starts;
  int         start_miss;
  int         width_bad;
  int         data_unstable;
  int         fin_early;
  logic       fin_end;
  logic [7:0] got [8];
  logic [7:0] exp_b [8];

  always #5 CLK = ~CLK;

  bip_report_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .INSTRUCTION (INSTRUCTION),
    .ADDR_PM     (ADDR_PM),
    .ACC         (ACC),
    .TX_DONE     (TX_DONE),
    .CPU_EN      (CPU_EN),
    .TX_DATA     (TX_DATA),
    .TX_START    (TX_START),
    .FINISHED    (FINISHED)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] nonhalt_instr();
    logic [4:0]  op;
    logic [10:0] operand;
    op      = 5'($urandom_range(1, 31));
    operand = 11'($urandom);
    return {op, operand};
  endfunction

  // Reference frame: header, PC, ACC, saturated cycle count, XOR checksum.
  task automatic build_expected(input logic [10:0] pc, input logic [15:0] acc, input int n_run);
    logic [15:0] cyc;
    logic [7:0]  sum;
    cyc = (n_run > 65535) ? 16'hFFFF : 16'(n_run);
    exp_b[0] = 8'hA5;
    exp_b[1] = {5'b00000, pc[10:8]};
    exp_b[2] = pc[7:0];
    exp_b[3] = acc[15:8];
    exp_b[4] = acc[7:0];
    exp_b[5] = cyc[15:8];
    exp_b[6] = cyc[7:0];
    sum = 8'h00;
    for (int i = 0; i < 7; i++) sum = sum ^ exp_b[i];
    exp_b[7] = sum;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    START = 1'b0;
    TX_DONE = 1'b0;
    INSTRUCTION = nonhalt_instr();
    repeat (2) step();
    RESET = 1'b1;
    step();
  endtask

  // Drives START, n_run CPU cycles (halt on the last), then acts as the UART
  // with random TX_DONE delays. Stops in WAIT_TX of abort_byte if >= 0.
  task automatic run_program(input int n_run, input logic [10:0] halt_pc,
                             input logic [15:0] halt_acc, input int inject_at,
                             input int abort_byte);
    int d;
    en_cycles = 0; run_tx_starts = 0; start_miss = 0; width_bad = 0;
    data_unstable = 0; fin_early = 0; fin_end = 1'b0;
    for (int i = 0; i < 8; i++) got[i] = 8'h00;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < n_run; k++) begin
      if (k == n_run - 1) begin
        INSTRUCTION = {5'b00000, 11'($urandom)};
        ADDR_PM = halt_pc;
        ACC = halt_acc;
      end else begin
        INSTRUCTION = nonhalt_instr();
        ADDR_PM = 11'(k);
        ACC = 16'($urandom);
      end
      if (k == inject_at) begin
        START = 1'b1;
        TX_DONE = 1'b1;
      end
      if (CPU_EN) en_cycles++;
      if (TX_START) run_tx_starts++;
      if (FINISHED) fin_early++;
      step();
      START = 1'b0;
      TX_DONE = 1'b0;
    end
    // Halt opcode stays on the bus afterwards; it must have no effect.
    INSTRUCTION = 16'h0000;
    ACC = 16'($urandom);
    for (int b = 0; b < 8; b++) begin
      if (!TX_START) start_miss++;
      got[b] = TX_DATA;
      if (CPU_EN) en_cycles++;
      if (FINISHED) fin_early++;
      step();
      if (b == abort_byte) return;
      d = $urandom_range(0, 3);
      for (int w = 0; w <= d; w++) begin
        if (TX_START) width_bad++;
        if (TX_DATA !== got[b]) data_unstable++;
        if (CPU_EN) en_cycles++;
        if (FINISHED) fin_early++;
        if (w == d) TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;
      end
    end
    fin_end = FINISHED;
    if (CPU_EN) en_cycles++;
    if (TX_START) width_bad++;
  endtask

  task automatic test_reset();
    int busy;
    RESET = 1'b0;
    #3;
    checks++; if (CPU_EN !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b want 0", CPU_EN); end
    checks++; if (TX_START !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", TX_START); end
    checks++; if (FINISHED !== 1'b0) begin errors++; $display("FAIL reset_finished: got %b want 0", FINISHED); end
    checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", TX_DATA); end
    step();
    RESET = 1'b1;
    // Halt opcode and TX_DONE in IDLE must not start anything.
    INSTRUCTION = 16'h0000;
    busy = 0;
    for (int i = 0; i < 8; i++) begin
      TX_DONE = i[0];
      step();
      if (CPU_EN || TX_START || FINISHED) busy++;
    end
    TX_DONE = 1'b0;
    checks++; if (busy !== 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles want 0", busy); end
  endtask

  task automatic test_basic();
    do_reset();
    build_expected(11'd3, 16'h1234, 4);
    run_program(4, 11'd3, 16'h1234, -1, -1);
    checks++; if (en_cycles !== 4) begin errors++; $display("FAIL basic_cpu_en: got %0d cycles want 4", en_cycles); end
    for (int b = 0; b < 8; b++) begin
      checks++; if (got[b] !== exp_b[b]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", b, got[b], exp_b[b]); end
    end
    checks++; if (got[7] !== 8'h84) begin errors++; $display("FAIL basic_checksum: got %h want 84", got[7]); end
    checks++; if (start_miss + width_bad + data_unstable !== 0) begin errors++;
      $display("FAIL basic_handshake: miss=%0d extra=%0d unstable=%0d want 0", start_miss, width_bad, data_unstable); end
    checks++; if (fin_end !== 1'b1 || fin_early !== 0) begin errors++;
      $display("FAIL basic_finished: end=%b early=%0d want 1/0", fin_end, fin_early); end
  endtask

  task automatic test_first_halt();
    do_reset();
    build_expected(11'd0, 16'h0000, 1);
    run_program(1, 11'd0, 16'h0000, -1, -1);
    for (int b = 0; b < 8; b++) begin
      checks++; if (got[b] !== exp_b[b]) begin errors++; $display("FAIL first_byte%0d: got %h want %h", b, got[b], exp_b[b]); end
    end
    checks++; if (got[6] !== 8'h01 || got[7] !== 8'hA4) begin errors++;
      $display("FAIL first_cyc_sum: got %h %h want 01 a4", got[6], got[7]); end
    checks++; if (fin_end !== 1'b1) begin errors++; $display("FAIL first_finished: got %b want 1", fin_end); end
    checks++; if (en_cycles !== 1) begin errors++; $display("FAIL first_cpu_en: got %0d want 1", en_cycles); end
  endtask

  task automatic test_saturate();
    logic [15:0] acc;
    acc = 16'($urandom);
    do_reset();
    build_expected(11'h155, acc, 70000);
    run_program(70000, 11'h155, acc, -1, -1);
    checks++; if (got[5] !== 8'hFF || got[6] !== 8'hFF) begin errors++;
      $display("FAIL sat_cyc: got %h%h want ffff", got[5], got[6]); end
    checks++; if (got[7] !== exp_b[7]) begin errors++; $display("FAIL sat_checksum: got %h want %h", got[7], exp_b[7]); end
    checks++; if (en_cycles !== 70000) begin errors++; $display("FAIL sat_cpu_en: got %0d want 70000", en_cycles); end
  endtask

  task automatic test_max_pc();
    int          n;
    logic [15:0] acc;
    n = $urandom_range(2, 20);
    acc = 16'($urandom);
    do_reset();
    build_expected(11'h7FF, acc, n);
    run_program(n, 11'h7FF, acc, -1, -1);
    checks++; if (got[1] !== 8'h07 || got[2] !== 8'hFF) begin errors++;
      $display("FAIL maxpc_bytes: got %h %h want 07 ff", got[1], got[2]); end
    for (int b = 0; b < 8; b++) begin
      checks++; if (got[b] !== exp_b[b]) begin errors++; $display("FAIL maxpc_byte%0d: got %h want %h", b, got[b], exp_b[b]); end
    end
    checks++; if (start_miss !== 0 || width_bad !== 0) begin errors++;
      $display("FAIL maxpc_pulses: missing=%0d extra=%0d want 0", start_miss, width_bad); end
  endtask

  task automatic test_random();
    int          n;
    logic [10:0] pc;
    logic [15:0] acc;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 300);
      pc = 11'($urandom);
      acc = 16'($urandom);
      do_reset();
      build_expected(pc, acc, n);
      run_program(n, pc, acc, -1, -1);
      for (int b = 0; b < 8; b++) begin
        checks++; if (got[b] !== exp_b[b]) begin errors++;
          $display("FAIL rand%0d_byte%0d: got %h want %h", r, b, got[b], exp_b[b]); end
      end
      checks++; if (start_miss + width_bad + data_unstable !== 0 || en_cycles !== n) begin errors++;
        $display("FAIL rand%0d_handshake: miss=%0d extra=%0d unstable=%0d en=%0d want 0/0/0/%0d",
                 r, start_miss, width_bad, data_unstable, en_cycles, n); end
    end
  endtask

  task automatic test_ignored();
    int busy;
    int lost;
    do_reset();
    build_expected(11'h0AB, 16'hBEEF, 6);
    run_program(6, 11'h0AB, 16'hBEEF, 2, -1);
    checks++; if (run_tx_starts !== 0) begin errors++; $display("FAIL ign_run_tx_start: got %0d want 0", run_tx_starts); end
    checks++; if (got[6] !== exp_b[6] || en_cycles !== 6) begin errors++;
      $display("FAIL ign_run_count: got cyc=%h en=%0d want %h/6", got[6], en_cycles, exp_b[6]); end
    // START and TX_DONE pulses in DONE must leave it parked.
    busy = 0;
    lost = 0;
    for (int i = 0; i < 10; i++) begin
      START = i[0];
      TX_DONE = ~i[0];
      step();
      if (CPU_EN || TX_START) busy++;
      if (!FINISHED) lost++;
    end
    START = 1'b0;
    TX_DONE = 1'b0;
    checks++; if (busy !== 0 || lost !== 0) begin errors++;
      $display("FAIL ign_done: active=%0d not_finished=%0d want 0/0", busy, lost); end
  endtask

  task automatic test_reset_mid_frame();
    int busy;
    // Async reset while running drops CPU_EN without a clock edge.
    do_reset();
    START = 1'b1;
    step();
    START = 1'b0;
    INSTRUCTION = nonhalt_instr();
    step();
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (CPU_EN !== 1'b0) begin errors++; $display("FAIL rst_run_cpu_en: got %b want 0", CPU_EN); end
    step();
    RESET = 1'b1;
    step();
    // Async reset in WAIT_TX of byte 4.
    run_program(5, 11'h123, 16'h005A, -1, 4);
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (CPU_EN !== 1'b0 || TX_START !== 1'b0 || FINISHED !== 1'b0) begin errors++;
      $display("FAIL rst_frame_outputs: got en=%b start=%b fin=%b want 0", CPU_EN, TX_START, FINISHED); end
    checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL rst_frame_data: got %h want 00", TX_DATA); end
    step();
    RESET = 1'b1;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      TX_DONE = i[0];
      step();
      if (CPU_EN || TX_START || FINISHED) busy++;
    end
    TX_DONE = 1'b0;
    checks++; if (busy !== 0) begin errors++; $display("FAIL rst_idle_quiet: got %0d active cycles want 0", busy); end
    // A fresh run after the abort produces a complete, correct frame.
    build_expected(11'h042, 16'hC0DE, 3);
    run_program(3, 11'h042, 16'hC0DE, -1, -1);
    for (int b = 0; b < 8; b++) begin
      checks++; if (got[b] !== exp_b[b]) begin errors++;
        $display("FAIL rst_rerun_byte%0d: got %h want %h", b, got[b], exp_b[b]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_first_halt();
    test_saturate();
    test_max_pc();
    test_random();
    test_ignored();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
